feed_sequencer: RTL and testbench

Paces market-data samples from the sample ROM into the TLU. The TLU runs on the fast core clock, while samples arrive at a much lower, programmable rate. This block sits between the ROM and the TLU. It runs a programmable interval timer, fetches one ROM word per tick, and presents it on a valid/ready handshake. It replaces free-running enable strobes, and it detects end-of-data and counts overruns when the consumer stalls.

---
 rtl/feed_sequencer.sv | 172 +++++++++++++++++
 tb/tb_feed_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/feed_sequencer.sv
// feed_sequencer: paces samples from a synchronous ROM into a valid/ready consumer.
// A programmable interval timer generates ticks; each tick fetches one ROM word,
// which is then held on sample_data until the consumer accepts it. Ticks that
// land while a sample is still in flight are dropped and counted as overruns.
//
// Optional feature macro: FEED_LOOP_EN
//   defined   - the run wraps from last_addr back to address 0 indefinitely.
//   undefined - the run stops in DONE after the sample at last_addr is accepted.
module feed_sequencer #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DIV_WIDTH-1:0]  interval,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            overrun_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StFetch,
    StPresent,
    StDone
  } state_e;

  // Periods shorter than 3 cycles cannot fit WAIT, FETCH and PRESENT.
  localparam logic [DIV_WIDTH-1:0] IntervalMin = DIV_WIDTH'(2);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   last_q, last_d;
  logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]    interval_q, interval_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [7:0]              ovr_q, ovr_d;

  logic                    running;
  logic                    tick;
  logic [DIV_WIDTH-1:0]    interval_clamped;
  logic [7:0]              ovr_inc;

  // Run-status decode, tick detection and helper values.
  always_comb begin
    running          = (state_q == StWait) || (state_q == StFetch) || (state_q == StPresent);
    tick             = running && (cnt_q == interval_q);
    interval_clamped = (interval < IntervalMin) ? IntervalMin : interval;
    ovr_inc          = (ovr_q == 8'hFF) ? ovr_q : ovr_q + 8'd1;
  end

  // Next-state logic for the FSM, timer and datapath registers.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    interval_d = interval_q;
    data_d     = data_q;
    ovr_d      = ovr_q;

    // Free-running timer while a run is active; it does not care about the FSM phase.
    if (running) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          state_d    = StWait;
          addr_d     = '0;
          cnt_d      = '0;
          ovr_d      = '0;
          interval_d = interval_clamped;
          last_d     = last_addr;
        end
      end

      StWait: begin
        if (stop) begin
          state_d = StIdle;
        end else if (tick) begin
          state_d = StFetch;
        end
      end

      StFetch: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          // rom_addr has been stable since at least the previous cycle, so rom_dout is valid.
          data_d  = rom_dout;
          state_d = StPresent;
          if (tick) begin
            ovr_d = ovr_inc;
          end
        end
      end

      StPresent: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          if (tick) begin
            ovr_d = ovr_inc;
          end
          if (sample_ready) begin
            if (addr_q == last_q) begin
`ifdef FEED_LOOP_EN
              addr_d  = '0;
              state_d = StWait;
`else
              state_d = StDone;
`endif
            end else begin
              addr_d  = addr_q + ADDR_WIDTH'(1);
              state_d = StWait;
            end
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      interval_q <= IntervalMin;
      data_q     <= '0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      interval_q <= interval_d;
      data_q     <= data_d;
      ovr_q      <= ovr_d;
    end
  end

  // Outputs are decoded from registered state so they drop as soon as reset asserts.
  always_comb begin
    rom_addr     = addr_q;
    sample_data  = data_q;
    sample_valid = (state_q == StPresent);
    busy         = running;
    done         = (state_q == StDone);
    overrun_cnt  = ovr_q;
  end

endmodule

// File: tb/tb_feed_sequencer.sv
// Directed bench for feed_sequencer. Cycle k means the k-th cycle after the one in
// which start was sampled; outputs are sampled 1 time unit after each rising edge.
module tb_feed_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] interval;
  logic [15:0] last_addr;
  logic [15:0] rom_addr;
  logic [7:0]  rom_dout;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        done;
  logic [7:0]  overrun_cnt;

  int n_total = 0;
  int n_bad   = 0;

  feed_sequencer #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .DIV_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .interval     (interval),
    .last_addr    (last_addr),
    .rom_addr     (rom_addr),
    .rom_dout     (rom_dout),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done),
    .overrun_cnt  (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model: ROM[a] = 10*(a+1) for the low 16 addresses.
  always @(posedge clk) rom_dout <= 8'((32'(rom_addr[3:0]) + 1) * 10);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns while observing cycle 1 of the run.
  task automatic do_start(input logic [15:0] intv, input logic [15:0] last);
    start     = 1'b1;
    interval  = intv;
    last_addr = last;
    step();
    start     = 1'b0;
  endtask

  // Start a run with ready held high and check pulse timing, data, done and overruns.
  task automatic run_stream(input string tag, input logic [15:0] intv, input logic [15:0] last,
                            input int first, input int period, input int n_exp, input int wrap,
                            input int horizon, input int exp_done);
    int n;
    int first_done;
    n          = 0;
    first_done = 0;
    sample_ready = 1'b1;
    do_start(intv, last);
    check_eq({tag, "_busy"}, 32'(busy), 1);
    check_eq({tag, "_done0"}, 32'(done), 0);
    for (int k = 2; k <= horizon; k++) begin
      step();
      if (sample_valid) begin
        if (n < n_exp) begin
          check_eq({tag, "_vcyc"}, 32'(k), 32'(first + n * period));
          check_eq({tag, "_data"}, 32'(sample_data), 32'(10 * ((n % wrap) + 1)));
        end
        n++;
      end
      if (done && first_done == 0) first_done = k;
    end
    check_eq({tag, "_nvalid"}, 32'(n), 32'(n_exp));
    check_eq({tag, "_donecyc"}, 32'(first_done), 32'(exp_done));
    check_eq({tag, "_ovr"}, 32'(overrun_cnt), 0);
  endtask

  initial begin
    int hold_err;
    rst          = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    interval     = '0;
    last_addr    = '0;
    sample_ready = 1'b0;
    step();
    step();
    check_eq("rst_valid", 32'(sample_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_addr", 32'(rom_addr), 0);
    check_eq("rst_data", 32'(sample_data), 0);
    check_eq("rst_ovr", 32'(overrun_cnt), 0);
    rst = 1'b0;
    step();

`ifdef FEED_LOOP_EN
    // Looping run: 10,20,10,20,... every 3 cycles; done never asserts.
    run_stream("loop", 16'd2, 16'd1, 5, 3, 6, 2, 21, 0);
    check_eq("loop_busy", 32'(busy), 1);
`else
    // Basic run: interval 60, four samples, done after the last handshake.
    run_stream("t1", 16'd60, 16'd3, 63, 61, 4, 4, 250, 247);

    // Consumer stall: three ticks fall on the pending sample.
    sample_ready = 1'b0;
    hold_err     = 0;
    do_start(16'd60, 16'd3);
    check_eq("t2_done_clr", 32'(done), 0);
    for (int k = 2; k <= 307; k++) begin
      step();
      sample_ready = (k >= 246);
      if (k >= 64 && k <= 245) begin
        if (!sample_valid || sample_data !== 8'd10) hold_err++;
      end
      if (k == 63) check_eq("t2_v63", 32'(sample_valid), 1);
      if (k == 246) begin
        check_eq("t2_ovr", 32'(overrun_cnt), 3);
        check_eq("t2_d246", 32'(sample_data), 10);
      end
      if (k == 306) check_eq("t2_v306", 32'(sample_valid), 0);
      if (k == 307) begin
        check_eq("t2_v307", 32'(sample_valid), 1);
        check_eq("t2_d307", 32'(sample_data), 20);
      end
    end
    check_eq("t2_hold", 32'(hold_err), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("t2_stopped", 32'(busy), 0);

    // Stop while PRESENT holding the second sample.
    sample_ready = 1'b1;
    do_start(16'd2, 16'd3);
    for (int k = 2; k <= 9; k++) begin
      step();
      sample_ready = (k <= 5);
      stop         = (k == 8);
      if (k == 8) begin
        check_eq("t3_v8", 32'(sample_valid), 1);
        check_eq("t3_d8", 32'(sample_data), 20);
      end
      if (k == 9) begin
        check_eq("t3_valid", 32'(sample_valid), 0);
        check_eq("t3_busy", 32'(busy), 0);
        check_eq("t3_addr", 32'(rom_addr), 1);
        check_eq("t3_done", 32'(done), 0);
      end
    end
    stop = 1'b0;
    sample_ready = 1'b1;
    do_start(16'd2, 16'd3);
    check_eq("t3_addr0", 32'(rom_addr), 0);
    for (int k = 2; k <= 5; k++) step();
    check_eq("t3_rv", 32'(sample_valid), 1);
    check_eq("t3_rd", 32'(sample_data), 10);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Interval 0 clamps to period 3.
    run_stream("t4", 16'd0, 16'd2, 5, 3, 3, 4, 14, 12);

    // Asynchronous reset in the middle of FETCH.
    do_start(16'd0, 16'd3);
    step();
    step();
    step();
    check_eq("t5_busy", 32'(busy), 1);
    check_eq("t5_fetch_v", 32'(sample_valid), 0);
    rst = 1'b1;
    #1;
    check_eq("t5_busy0", 32'(busy), 0);
    check_eq("t5_valid0", 32'(sample_valid), 0);
    check_eq("t5_done0", 32'(done), 0);
    check_eq("t5_data0", 32'(sample_data), 0);
    check_eq("t5_addr0", 32'(rom_addr), 0);
    check_eq("t5_ovr0", 32'(overrun_cnt), 0);
    step();
    rst = 1'b0;
    step();
    run_stream("t5", 16'd2, 16'd0, 5, 3, 1, 1, 8, 6);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
